// File: rtl/servo_pkg.sv
// Shared types and constants for the five-servo ramp scheduler.
package servo_pkg;

  localparam int NUM_SERVOS   = 5;
  localparam int ANG_W        = 8;
  localparam int DIST_W       = 9;
  localparam int IDX_W        = 3;
  localparam int DEF_TICK_DIV = 50000;
  localparam int DEF_MIN_DIST = 10;
  localparam int DEF_HOME_ANG = 90;
  localparam int DEF_MAX_ANG  = 180;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [ANG_W-1:0] clamp_ang(input logic [ANG_W-1:0] a,
                                                 input logic [ANG_W-1:0] max_a);
    return (a > max_a) ? max_a : a;
  endfunction

  // Saturating single-unit move; equal inputs return the current angle.
  function automatic logic [ANG_W-1:0] step_toward(input logic [ANG_W-1:0] cur,
                                                   input logic [ANG_W-1:0] tgt);
    logic [ANG_W-1:0] res;
    if (cur < tgt) begin
      res = cur + ANG_W'(1);
    end else if (cur > tgt) begin
      res = cur - ANG_W'(1);
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Ramp-step pulse generator: counts enabled cycles and pulses on the last one.
module step_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign tick   = en && w_last;

  // Count only while enabled so a paused move resumes at the same phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/servo_ramp_scheduler.sv
// Five-servo ramp scheduler: moves servos one unit per step, strictly in order 1..5.
// Optional obstacle pause is built when the SAFETY_STOP_EN macro is defined.
module servo_ramp_scheduler
  import servo_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int MIN_DIST = DEF_MIN_DIST,
  parameter int HOME_ANG = DEF_HOME_ANG,
  parameter int MAX_ANG  = DEF_MAX_ANG
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SERVOS*ANG_W-1:0] tgt_angles,
  input  logic                        tgt_valid,
  output logic                        tgt_ready,
  input  logic [DIST_W-1:0]           distancia,
  output logic [ANG_W-1:0]            ang_servo_1,
  output logic [ANG_W-1:0]            ang_servo_2,
  output logic [ANG_W-1:0]            ang_servo_3,
  output logic [ANG_W-1:0]            ang_servo_4,
  output logic [ANG_W-1:0]            ang_servo_5,
  output logic                        busy,
  output logic                        done,
  output logic                        paused
);

  localparam logic [ANG_W-1:0] HOME_A   = ANG_W'(HOME_ANG);
  localparam logic [ANG_W-1:0] MAX_A    = ANG_W'(MAX_ANG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SERVOS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ANG_W-1:0] r_ang [NUM_SERVOS];
  logic [ANG_W-1:0] r_tgt [NUM_SERVOS];
  logic [IDX_W-1:0] r_idx;
  logic             r_tgt_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_paused;

  logic             w_accept;
  logic             w_obstacle;
  logic             w_tick_en;
  logic             w_tick_rst;
  logic             w_tick;
  logic             w_step;
  logic             w_at_tgt;
  logic             w_last_step;

`ifdef SAFETY_STOP_EN
  // Zero distance means no echo, so only a non-zero short reading is an obstacle.
  assign w_obstacle = (distancia != DIST_W'(0)) && (distancia < DIST_W'(MIN_DIST));
`else
  logic w_unused_dist;
  assign w_unused_dist = ^distancia;
  assign w_obstacle    = 1'b0;
`endif

  assign w_accept    = r_tgt_ready && tgt_valid;
  assign w_tick_en   = (r_state == ST_MOVE) && !w_obstacle;
  assign w_tick_rst  = rst || w_accept;
  assign w_step      = w_tick && (r_state == ST_MOVE);
  assign w_at_tgt    = (r_ang[r_idx] == r_tgt[r_idx]);
  assign w_last_step = w_step && w_at_tgt && (r_idx == LAST_IDX);

  step_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (w_tick_rst),
    .en   (w_tick_en),
    .tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; an obstacle outranks the final step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_MOVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (w_obstacle) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_last_step) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_MOVE;
        end
      end
      ST_PAUSE: begin
        if (!w_obstacle) begin
          w_state_nxt = ST_MOVE;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they track r_state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tgt_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_paused    <= 1'b0;
    end else begin
      r_tgt_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt == ST_MOVE) || (w_state_nxt == ST_PAUSE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_paused    <= (w_state_nxt == ST_PAUSE);
    end
  end

  // Target latch and per-step angle update for the servo selected by r_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SERVOS; i++) begin
        r_ang[i] <= HOME_A;
        r_tgt[i] <= HOME_A;
      end
      r_idx <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_SERVOS; i++) begin
        r_tgt[i] <= clamp_ang(tgt_angles[i*ANG_W +: ANG_W], MAX_A);
      end
      r_idx <= '0;
    end else if (w_step) begin
      if (!w_at_tgt) begin
        r_ang[r_idx] <= step_toward(r_ang[r_idx], r_tgt[r_idx]);
      end else if (r_idx != LAST_IDX) begin
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_idx <= r_idx;
      end
    end else begin
      r_idx <= r_idx;
    end
  end

  assign ang_servo_1 = r_ang[0];
  assign ang_servo_2 = r_ang[1];
  assign ang_servo_3 = r_ang[2];
  assign ang_servo_4 = r_ang[3];
  assign ang_servo_5 = r_ang[4];
  assign tgt_ready   = r_tgt_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign paused      = r_paused;

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Directed bench for servo_ramp_scheduler with TICK_DIV=4 and MIN_DIST=10.
module tb_servo_ramp_scheduler;

  localparam int TICK_DIV = 4;
  localparam int BUDGET   = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] tgt_angles;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [8:0]  distancia;
  logic [7:0]  ang_servo_1, ang_servo_2, ang_servo_3, ang_servo_4, ang_servo_5;
  logic        busy, done, paused;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0][7:0] tgt;
    logic [4:0][7:0] exp_ang;
    int              exp_cyc;
    int              probe_cyc;
    int              probe_srv;
    int              probe_val;
  } vec_t;

  vec_t vecs[5];

  servo_ramp_scheduler #(
    .TICK_DIV (TICK_DIV),
    .MIN_DIST (10),
    .HOME_ANG (90),
    .MAX_ANG  (180)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tgt_angles  (tgt_angles),
    .tgt_valid   (tgt_valid),
    .tgt_ready   (tgt_ready),
    .distancia   (distancia),
    .ang_servo_1 (ang_servo_1),
    .ang_servo_2 (ang_servo_2),
    .ang_servo_3 (ang_servo_3),
    .ang_servo_4 (ang_servo_4),
    .ang_servo_5 (ang_servo_5),
    .busy        (busy),
    .done        (done),
    .paused      (paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ang_of(input int s);
    case (s)
      0:       return int'(ang_servo_1);
      1:       return int'(ang_servo_2);
      2:       return int'(ang_servo_3);
      3:       return int'(ang_servo_4);
      default: return int'(ang_servo_5);
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_move(input vec_t v, input string nm);
    int  prev[5];
    int  cur[5];
    int  n = 0;
    int  chg;
    int  step_viol = 0;
    int  order_viol = 0;
    int  paused_cnt = 0;
    int  probe_got = -1;
    bit  seen = 1'b0;
    for (int i = 0; i < 5; i++) prev[i] = ang_of(i);
    tgt_angles = v.tgt;
    tgt_valid  = 1'b1;
    cyc();
    tgt_valid  = 1'b0;
    check({nm, " busy_after_accept"}, int'(busy), 1);
    check({nm, " ready_after_accept"}, int'(tgt_ready), 0);
    while (!seen && n < BUDGET) begin
      cyc();
      n++;
      chg = 0;
      for (int j = 0; j < 5; j++) begin
        cur[j] = ang_of(j);
        if (cur[j] != prev[j]) begin
          chg++;
          if (cur[j] - prev[j] > 1 || prev[j] - cur[j] > 1) step_viol++;
          for (int i = 0; i < j; i++)
            if (cur[i] != int'(v.exp_ang[i])) order_viol++;
        end
      end
      if (chg > 1) step_viol++;
      if (paused) paused_cnt++;
      if (n == v.probe_cyc) probe_got = cur[v.probe_srv];
      if (done) seen = 1'b1;
      for (int j = 0; j < 5; j++) prev[j] = cur[j];
    end
    check({nm, " done_cycle"}, seen ? n : -1, v.exp_cyc);
    check({nm, " probe_angle"}, probe_got, v.probe_val);
    check({nm, " single_unit_steps"}, step_viol, 0);
    check({nm, " servo_order"}, order_viol, 0);
    check({nm, " paused_cycles"}, paused_cnt, 0);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s final_servo_%0d", nm, i + 1), ang_of(i), int'(v.exp_ang[i]));
    cyc();
    check({nm, " done_one_cycle"}, int'(done), 0);
    check({nm, " ready_after_done"}, int'(tgt_ready), 1);
  endtask

  initial begin
    int viol;
    int done_seen;

    vecs[0] = '{tgt: {8'd93, 8'd90, 8'd90, 8'd90, 8'd90},  exp_ang: {8'd93, 8'd90, 8'd90, 8'd90, 8'd90},
                exp_cyc: 32,   probe_cyc: 24,  probe_srv: 4, probe_val: 92};
    vecs[1] = '{tgt: {8'd93, 8'd90, 8'd90, 8'd90, 8'd90},  exp_ang: {8'd93, 8'd90, 8'd90, 8'd90, 8'd90},
                exp_cyc: 20,   probe_cyc: 4,   probe_srv: 4, probe_val: 93};
    vecs[2] = '{tgt: {8'd90, 8'd90, 8'd90, 8'd88, 8'd200}, exp_ang: {8'd90, 8'd90, 8'd90, 8'd88, 8'd180},
                exp_cyc: 400,  probe_cyc: 368, probe_srv: 1, probe_val: 89};
    vecs[3] = '{tgt: {8'd90, 8'd100, 8'd45, 8'd255, 8'd0}, exp_ang: {8'd90, 8'd100, 8'd45, 8'd180, 8'd0},
                exp_cyc: 1328, probe_cyc: 4,   probe_srv: 0, probe_val: 179};
    vecs[4] = '{tgt: {8'd90, 8'd90, 8'd90, 8'd90, 8'd90},  exp_ang: {8'd90, 8'd90, 8'd90, 8'd90, 8'd90},
                exp_cyc: 960,  probe_cyc: 4,   probe_srv: 0, probe_val: 1};

    rst        = 1'b1;
    tgt_valid  = 1'b0;
    tgt_angles = '0;
    distancia  = 9'd0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 5; i++) check($sformatf("reset servo_%0d", i + 1), ang_of(i), 90);
    check("reset tgt_ready", int'(tgt_ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset paused", int'(paused), 0);

    for (int k = 0; k < 5; k++) run_move(vecs[k], $sformatf("vec%0d", k));

    // tgt_valid held during MOVE, then reset after the third step.
    tgt_angles = {8'd90, 8'd90, 8'd90, 8'd90, 8'd95};
    tgt_valid  = 1'b1;
    cyc();
    tgt_angles = '0;
    viol = 0;
    done_seen = 0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      if (tgt_ready) viol++;
      if (done) done_seen++;
    end
    check("hold ready_low_in_move", viol, 0);
    check("hold servo1_after_3_steps", int'(ang_servo_1), 93);
    check("hold busy", int'(busy), 1);
    rst       = 1'b1;
    tgt_valid = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) check($sformatf("midrst servo_%0d", i + 1), ang_of(i), 90);
    check("midrst tgt_ready", int'(tgt_ready), 1);
    check("midrst busy", int'(busy), 0);
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (done || busy) done_seen++;
    end
    check("midrst no_done_no_busy", done_seen, 0);

`ifdef SAFETY_STOP_EN
    tgt_angles = {8'd90, 8'd90, 8'd90, 8'd90, 8'd100};
    tgt_valid  = 1'b1;
    cyc();
    tgt_valid = 1'b0;
    repeat (6) cyc();
    check("obst servo1_before", int'(ang_servo_1), 91);
    distancia = 9'd5;
    cyc();
    check("obst paused", int'(paused), 1);
    check("obst busy_in_pause", int'(busy), 1);
    viol = 0;
    for (int n = 0; n < 100; n++) begin
      cyc();
      if (!paused || ang_servo_1 != 8'd91 || ang_servo_2 != 8'd90) viol++;
    end
    check("obst frozen_100", viol, 0);
    distancia = 9'd0;
    cyc();
    check("obst resume_on_zero", int'(paused), 0);
    cyc();
    check("obst phase_hold", int'(ang_servo_1), 91);
    cyc();
    check("obst phase_step", int'(ang_servo_1), 92);
    distancia = 9'd9;
    cyc();
    check("obst pause_at_9", int'(paused), 1);
    distancia = 9'd10;
    cyc();
    check("obst resume_at_10", int'(paused), 0);
    viol = -1;
    for (int n = 1; n <= 200 && viol < 0; n++) begin
      cyc();
      if (done) viol = n;
    end
    check("obst completes", (viol > 0) ? 1 : 0, 1);
    check("obst servo1_final", int'(ang_servo_1), 100);
    distancia = 9'd0;
    cyc();
`else
    distancia = 9'd1;
    run_move('{tgt: {8'd90, 8'd90, 8'd90, 8'd90, 8'd92}, exp_ang: {8'd90, 8'd90, 8'd90, 8'd90, 8'd92},
               exp_cyc: 28, probe_cyc: 4, probe_srv: 0, probe_val: 91}, "nostop");
    distancia = 9'd0;
`endif

    // Reset wins over a simultaneous tgt_valid.
    tgt_angles = {8'd90, 8'd90, 8'd90, 8'd90, 8'd120};
    tgt_valid  = 1'b1;
    rst        = 1'b1;
    cyc();
    rst       = 1'b0;
    tgt_valid = 1'b0;
    check("rstprio busy", int'(busy), 0);
    check("rstprio tgt_ready", int'(tgt_ready), 1);
    repeat (8) cyc();
    check("rstprio servo1_home", int'(ang_servo_1), 90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_ramp_scheduler.md
SERVO_RAMP_SCHEDULER -- requirements
Module: servo_ramp_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000; clk cycles per ramp step (1 ms at 50 MHz).
REQ-002 Parameter MIN_DIST, default 10; obstacle threshold in distancia units.
REQ-003 Parameter HOME_ANG, default 90; reset and home angle for all servos.
REQ-004 Parameter MAX_ANG, default 180; upper angle clamp.
REQ-005 clk  in  1  single system clock; all logic is on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 tgt_angles  in  40  packed targets; [7:0] is servo 1 and [39:32] is servo 5.
REQ-008 tgt_valid  in  1  target set offered.
REQ-009 tgt_ready  out  1  high only in IDLE.
REQ-010 distancia  in  9  latest distance from the sensor controller.
REQ-011 ang_servo_1..ang_servo_5  out  8 each  commanded angles to the servo PWM blocks.
REQ-012 busy  out  1  high in MOVE or PAUSE.
REQ-013 done  out  1  one-cycle pulse when a move sequence completes.
REQ-014 paused  out  1  high in PAUSE.

Function
REQ-015 The block has four states: IDLE, MOVE, PAUSE, DONE.
REQ-016 Target acceptance: when tgt_valid && tgt_ready, the block latches each target byte, clamped to MAX_ANG, sets idx=0, clears the tick counter, and enters MOVE on the next cycle.
REQ-017 tgt_valid is ignored outside IDLE; no target queue exists.
REQ-018 MOVE: the tick counter counts 0..TICK_DIV-1; the cycle with count==TICK_DIV-1 is a step.
REQ-019 On a step, servo[idx] moves ±1 toward its target; if servo[idx] already equals its target, idx increments instead and no angle changes on that step.
REQ-020 Servos move strictly in order 1→5; only one angle changes per step.
REQ-021 On a step with idx==4 and servo 5 at its target, the block enters DONE.
REQ-022 DONE lasts exactly 1 cycle with done=1, then returns to IDLE.
REQ-023 A target set equal to the current angles completes in 5 steps, then done.
REQ-024 Sequence time in steps = Σ|tgt_i − ang_i| + 5.
REQ-025 Angles never leave 0..MAX_ANG; the ±1 step never wraps.
REQ-026 Outputs are registered; an angle changes 1 cycle after its step cycle.

Configuration
REQ-027 Macro SAFETY_STOP_EN.
REQ-028 When SAFETY_STOP_EN is defined: MOVE→PAUSE whenever 0 < distancia < MIN_DIST.
REQ-029 When SAFETY_STOP_EN is defined: PAUSE→MOVE whenever distancia==0 or distancia >= MIN_DIST.
REQ-030 When SAFETY_STOP_EN is defined: in PAUSE the tick counter and angles hold, and motion resumes with the same count.
REQ-031 When SAFETY_STOP_EN is defined: distancia==0 means no echo and is not treated as an obstacle.
REQ-032 When SAFETY_STOP_EN is defined: if an obstacle and the final step coincide, PAUSE takes priority and the step is not taken.
REQ-033 When SAFETY_STOP_EN is undefined: PAUSE is unreachable, paused is tied to 0, and distancia is unused.

Reset
REQ-034 On rst: state=IDLE, all angles=HOME_ANG, all targets=HOME_ANG, idx=0, tick counter=0.
REQ-035 On rst: done=0, busy=0, paused=0, tgt_ready=1 from the first cycle after reset.
REQ-036 rst asserted mid-MOVE or mid-PAUSE abandons the sequence and snaps all angles to HOME_ANG; done is not pulsed.
REQ-037 rst has priority over every other event, including a simultaneous tgt_valid.

Structure
REQ-038 A shared package servo_pkg holds: the state enum, NUM_SERVOS=5, ANG_W=8, DIST_W=9, and defaults for HOME_ANG and MAX_ANG.
REQ-039 One sub-module, step_tick_gen, produces the step pulse; it has inputs clk, rst, en, output tick, and parameter TICK_DIV.
REQ-040 Angle registers are an array indexed by idx, unpacked to the five output ports.

Verification (TICK_DIV=4, MIN_DIST=10, SAFETY_STOP_EN defined unless noted)
REQ-041 Reset check: after reset, every ang_servo_*=90, tgt_ready=1, busy=0.
REQ-042 Single servo move: targets {90,90,90,90,93} → servo 5 reads 91,92,93 at 4-cycle spacing; done pulses after 8 steps (32 cycles); no other angle moves.
REQ-043 Clamp and order: servo 1 target 200 (clamped to 180) and servo 2 target 88 → servo 1 reaches 180 before servo 2 starts to decrease; servo 2 ends at 88.
REQ-044 Obstacle: distancia=5 mid-MOVE → paused=1 and angles frozen for 100 cycles; distancia=0 → motion resumes with the same tick phase; distancia=9 → pause; distancia=10 → resume.
REQ-045 Handshake and reset: tgt_valid held during MOVE is ignored (tgt_ready=0); rst asserted at step 3 → all angles 90, IDLE, no done pulse.
REQ-046 Macro undefined: distancia=1 throughout a move → sequence completes and paused stays 0.
